// File: rtl/instr_load_encoder.sv
// Streams opcode/register field bundles into 32-bit words and writes
// them to instruction memory, holding the CPU in reset until done.
module instr_load_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [5:0]        in_rd,
  input  logic [5:0]        in_rs,
  input  logic [5:0]        in_rt,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_overflow,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [1:0] {
    S_IDLE, S_LOAD, S_WRITE, S_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W:0] DEPTH_C =
    {1'b1, {ADDR_W{1'b0}}};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                last_q, last_d;
  logic                ill_q, ill_d;
  logic                ovf_q, ovf_d;
  logic                hold_q, hold_d;
  logic                op_legal;
  logic [31:0]         enc;

  // Opcodes the control decoder has no entry for
  always_comb begin
    op_legal = 1'b1;
    case (in_op)
      4'b0001, 4'b0010,
      4'b1100, 4'b1101: op_legal = 1'b0;
      default:          op_legal = 1'b1;
    endcase
  end

  assign enc = (in_op == 4'b0000) ? 32'h0
             : {in_op, in_rd, in_rs, in_rt, 10'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      ill_q   <= 1'b0;
      ovf_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      ill_q   <= ill_d;
      ovf_q   <= ovf_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (start) state_d = S_LOAD;
      S_LOAD:
        if (in_valid) begin
          if (op_legal)     state_d = S_WRITE;
          else if (in_last) state_d = S_DONE;
        end
      S_WRITE:
        if (last_q || addr_q == ADDR_MAX)
          state_d = S_DONE;
        else
          state_d = S_LOAD;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    ill_d   = ill_q;
    ovf_d   = ovf_q;
    hold_d  = hold_q;
    unique case (state_q)
      S_IDLE:
        if (start) begin
          addr_d = '0;
          cnt_d  = '0;
          ill_d  = 1'b0;
          ovf_d  = 1'b0;
          hold_d = 1'b1;
        end
      S_LOAD:
        if (in_valid) begin
          if (op_legal) begin
            waddr_d = addr_q;
            wdata_d = enc;
            last_d  = in_last;
          end else begin
            ill_d = 1'b1;
          end
        end
      S_WRITE: begin
        // Address saturates at the top word rather than wrapping
        if (addr_q != ADDR_MAX)
          addr_d = addr_q + 1'b1;
        if (cnt_q != DEPTH_C)
          cnt_d = cnt_q + 1'b1;
        if (addr_q == ADDR_MAX && !last_q)
          ovf_d = 1'b1;
      end
      S_DONE:  hold_d = 1'b0;
      default: ;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_LOAD);
    imem_we  = (state_q == S_WRITE);
    done     = (state_q == S_DONE);
    busy     = (state_q == S_LOAD)
            || (state_q == S_WRITE);
  end

  assign imem_addr    = waddr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_hold     = hold_q;
  assign err_illegal  = ill_q;
  assign err_overflow = ovf_q;
  assign word_count   = cnt_q;

endmodule

// File: tb/tb_instr_load_encoder.sv
// Bench for instr_load_encoder: vector table, directed corner
// sequences and random sessions against a session-level model.
module tb_instr_load_encoder;

  localparam int AW = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [5:0]    in_rd, in_rs, in_rt;
  logic          in_last;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold, busy, done;
  logic          err_illegal, err_overflow;
  logic [AW:0]   word_count;

  instr_load_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs),
    .in_rt(in_rt), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done),
    .err_illegal(err_illegal),
    .err_overflow(err_overflow),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] op;
    logic [5:0] rd, rs, rt;
    logic       last;
  } bundle_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    logic [3:0]  op;
    logic [5:0]  rd, rs, rt;
    logic [31:0] exp_word;
    logic        exp_legal;
  } vec_t;

  int      tests = 0;
  int      failed = 0;
  int      done_cnt = 0;
  wr_t     got_q[$];
  bundle_t stim_q[$];

  always @(negedge clk) begin
    if (imem_we) got_q.push_back({imem_addr, imem_wdata});
    if (done) done_cnt++;
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic bit m_legal(input int op);
    int legal_ops[12] = '{0, 15, 14, 3, 4, 5,
                          6, 7, 8, 9, 10, 11};
    foreach (legal_ops[i])
      if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_enc(input bundle_t b);
    longint v;
    if (b.op == 0) return 32'h0;
    v = longint'(b.op) * (64'd1 << 28)
      + longint'(b.rd) * (64'd1 << 22)
      + longint'(b.rs) * (64'd1 << 16)
      + longint'(b.rt) * (64'd1 << 10);
    return v[31:0];
  endfunction

  task automatic drive(input bundle_t b);
    in_valid = 1'b1;
    in_op = b.op; in_rd = b.rd;
    in_rs = b.rs; in_rt = b.rt;
    in_last = b.last;
  endtask

  // Present a bundle from a negedge and wait for its handshake
  task automatic send(input bundle_t b);
    int t = 0;
    drive(b);
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("handshake_timeout", 64'(t < 20), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic begin_session();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_hold", 64'(cpu_hold), 64'd1);
    chk("start_wc", 64'(word_count), 64'd0);
    chk("start_errs",
        64'({err_illegal, err_overflow}), 64'd0);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || done) && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", 64'(t < 30), 64'd1);
  endtask

  // Model the session and check it end to end
  task automatic run_session();
    wr_t     exp_q[$];
    int      n = 0, used = 0;
    bit      eill = 0, eovf = 0;
    int      g0, d0;
    bundle_t xb;
    foreach (stim_q[i]) begin
      used = i + 1;
      if (!m_legal(int'(stim_q[i].op))) begin
        eill = 1;
        if (stim_q[i].last) break;
        continue;
      end
      exp_q.push_back({AW'(n), m_enc(stim_q[i])});
      n++;
      if (stim_q[i].last) break;
      if (n == DEPTH) begin
        eovf = 1;
        break;
      end
    end
    g0 = got_q.size();
    d0 = done_cnt;
    begin_session();
    for (int i = 0; i < used; i++) begin
      @(negedge clk);
      if (!in_ready) ;
      send(stim_q[i]);
    end
    // An extra bundle after the session must never be taken
    xb = '{op: 4'b0100, rd: 6'd1, rs: 6'd1,
           rt: 6'd1, last: 1'b0};
    drive(xb);
    repeat (8) @(negedge clk);
    in_valid = 1'b0;
    wait_idle();
    chk("done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("end_hold", 64'(cpu_hold), 64'd0);
    chk("end_wc", 64'(word_count), 64'(n));
    chk("end_ill", 64'(err_illegal), 64'(eill));
    chk("end_ovf", 64'(err_overflow), 64'(eovf));
    chk("num_writes", 64'(got_q.size() - g0),
        64'(exp_q.size()));
    foreach (exp_q[k])
      if (g0 + k < got_q.size())
        chk("write", 64'(got_q[g0 + k]),
            64'(exp_q[k]));
    if (exp_q.size() > 0)
      chk("wdata_hold", 64'(imem_wdata),
          64'(exp_q[exp_q.size() - 1].data));
  endtask

  function automatic bundle_t mk(input int op,
      input int rd, input int rs, input int rt,
      input bit last);
    bundle_t b;
    b.op = 4'(op); b.rd = 6'(rd);
    b.rs = 6'(rs); b.rt = 6'(rt);
    b.last = last;
    return b;
  endfunction

  initial begin
    vec_t vt[10];
    int   g0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    in_op = '0; in_rd = '0; in_rs = '0;
    in_rt = '0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hold", 64'(cpu_hold), 64'd1);
    chk("rst_outs",
        64'({busy, done, in_ready, imem_we,
             err_illegal, err_overflow}), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_wdata", 64'(imem_wdata), 64'd0);
    chk("rst_wc", 64'(word_count), 64'd0);
    rst = 1'b0;

    // Program: add r1,r2,r3 ; inc ; jump (last)
    stim_q = '{mk(4, 1, 2, 3, 0), mk(5, 4, 4, 0, 0),
               mk(11, 0, 0, 7, 1)};
    g0 = got_q.size();
    run_session();
    if (got_q.size() > g0)
      chk("t1_word0", 64'(got_q[g0].data),
          64'h4042_0C00);

    vt[0] = '{4'h4, 1, 2, 3, 32'h4042_0C00, 1};
    vt[1] = '{4'h0, 5, 7, 9, 32'h0000_0000, 1};
    vt[2] = '{4'hC, 1, 1, 1, 32'h0, 0};
    vt[3] = '{4'hF, 63, 63, 63, 32'hFFFF_FC00, 1};
    vt[4] = '{4'h1, 2, 3, 4, 32'h0, 0};
    vt[5] = '{4'h2, 2, 3, 4, 32'h0, 0};
    vt[6] = '{4'hD, 2, 3, 4, 32'h0, 0};
    vt[7] = '{4'hE, 0, 0, 1, 32'hE000_0400, 1};
    vt[8] = '{4'hB, 2, 0, 0, 32'hB080_0000, 1};
    vt[9] = '{4'h3, 0, 1, 0, 32'h3001_0000, 1};
    foreach (vt[i]) begin
      g0 = got_q.size();
      begin_session();
      send(mk(int'(vt[i].op), int'(vt[i].rd),
              int'(vt[i].rs), int'(vt[i].rt), 1));
      wait_idle();
      chk("vec_nwr", 64'(got_q.size() - g0),
          64'(vt[i].exp_legal));
      chk("vec_ill", 64'(err_illegal),
          64'(!vt[i].exp_legal));
      if (vt[i].exp_legal && got_q.size() > g0)
        chk("vec_word", 64'(got_q[g0].data),
            64'(vt[i].exp_word));
    end

    // Illegal mid-stream, then overflow with no last
    stim_q = '{mk(6, 1, 1, 1, 0), mk(12, 2, 2, 2, 0),
               mk(7, 3, 3, 3, 1)};
    run_session();
    stim_q = '{mk(4, 1, 0, 0, 0), mk(5, 2, 0, 0, 0),
               mk(6, 3, 0, 0, 0), mk(7, 4, 0, 0, 0),
               mk(8, 5, 0, 0, 0)};
    run_session();

    // Reset while WRITE is active
    begin_session();
    @(negedge clk);
    drive(mk(9, 1, 2, 3, 0));
    @(posedge clk);
    #2;
    chk("t5_we_before", 64'(imem_we), 64'd1);
    rst = 1'b1;
    #1;
    chk("t5_we", 64'(imem_we), 64'd0);
    chk("t5_hold", 64'(cpu_hold), 64'd1);
    chk("t5_outs", 64'({busy, done, err_illegal,
        err_overflow, imem_addr, imem_wdata,
        word_count}), 64'd0);
    in_valid = 1'b0;
    @(negedge clk) rst = 1'b0;

    // in_valid held in IDLE, start pulsed in LOAD
    g0 = got_q.size();
    @(negedge clk);
    drive(mk(4, 1, 1, 1, 1));
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    chk("t6_idle_nwr", 64'(got_q.size() - g0), 64'd0);
    chk("t6_idle_busy", 64'({busy, in_ready}), 64'd0);
    begin_session();
    send(mk(12, 1, 1, 1, 0));
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("t6_ill_kept", 64'(err_illegal), 64'd1);
    chk("t6_busy", 64'(busy), 64'd1);
    send(mk(5, 1, 1, 1, 1));
    wait_idle();
    chk("t6_wc", 64'(word_count), 64'd1);
    chk("t6_ill_end", 64'(err_illegal), 64'd1);
    chk("t6_nwr", 64'(got_q.size() - g0), 64'd1);
    if (got_q.size() > g0)
      chk("t6_addr", 64'(got_q[g0].addr), 64'd0);

    for (int s = 0; s < 30; s++) begin
      int len = $urandom_range(1, 6);
      stim_q.delete();
      for (int k = 0; k < len; k++)
        stim_q.push_back(mk(
          int'($urandom_range(0, 15)),
          int'($urandom_range(0, 63)),
          int'($urandom_range(0, 63)),
          int'($urandom_range(0, 63)),
          (k == len - 1) ||
          ($urandom_range(0, 9) == 0)));
      run_session();
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, failed);
    $finish;
  end

endmodule
